// File: rtl/life_stats_counter.sv
// life_stats_counter: births/generation statistics for the Game of Life engine.
// Watches the per-cell old/new beat stream of each update sweep, counts
// dead->alive transitions, and publishes saturating 16-bit births/generation
// values that only change on sweep commit, clear or reset.
//
// Optional feature macro: LIFE_STATS_PER_GEN_EN
//   defined   : births shows the births of the last completed generation only
//   undefined : births accumulates across generations (default)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          synchronous clear, overrides all other inputs
//   gen_start      pulse: engine begins a sweep
//   cell_valid     cell beat present (cell_old/cell_new valid)
//   cell_old/new   current/next state of the cell
//   births         birth count (registered, saturating)
//   generation     completed generations (registered, saturating)
//   busy           high while in SCAN or COMMIT
//   commit         one-cycle pulse when births/generation were updated
//   protocol_err   sticky protocol-violation flag
module life_stats_counter #(
  parameter int unsigned CELLS     = 64,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        gen_start,
  input  logic        cell_valid,
  input  logic        cell_old,
  input  logic        cell_new,
  output logic [15:0] births,
  output logic [15:0] generation,
  output logic        busy,
  output logic        commit,
  output logic        protocol_err
);

  localparam int unsigned CW = $clog2(CELLS + 1);
  localparam logic [15:0]   MAX16     = 16'(MAX_COUNT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] partial_q, partial_d;
  logic [15:0]   births_q, births_d;
  logic [15:0]   gen_q, gen_d;
  logic          busy_q, busy_d;
  logic          commit_q, commit_d;
  logic          perr_q, perr_d;

  logic [15:0]   births_next;
  logic [15:0]   gen_next;
  logic [16:0]   gen_sum;

  // Saturating values loaded on COMMIT exit; sums are formed one bit wider.
  always_comb begin
    births_next = births_q;
`ifdef LIFE_STATS_PER_GEN_EN
    if (32'(partial_q) > 32'(MAX_COUNT)) births_next = MAX16;
    else                                 births_next = 16'(partial_q);
`else
    begin
      logic [16:0] birth_sum;
      birth_sum = 17'(births_q) + 17'(partial_q);
      if (birth_sum > 17'(MAX_COUNT)) births_next = MAX16;
      else                            births_next = birth_sum[15:0];
    end
`endif
    gen_sum  = 17'(gen_q) + 17'd1;
    gen_next = (gen_sum > 17'(MAX_COUNT)) ? MAX16 : gen_sum[15:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      partial_q <= '0;
      births_q  <= '0;
      gen_q     <= '0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      partial_q <= partial_d;
      births_q  <= births_d;
      gen_q     <= gen_d;
      busy_q    <= busy_d;
      commit_q  <= commit_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    partial_d = partial_q;
    births_d  = births_q;
    gen_d     = gen_q;
    commit_d  = 1'b0;
    perr_d    = perr_q;

    if (clear) begin
      state_d   = IDLE;
      beat_d    = '0;
      partial_d = '0;
      births_d  = '0;
      gen_d     = '0;
      perr_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A beat alongside gen_start is flagged and not counted.
          if (cell_valid) perr_d = 1'b1;
          if (gen_start) begin
            state_d   = SCAN;
            beat_d    = '0;
            partial_d = '0;
          end
        end
        SCAN: begin
          if (gen_start) perr_d = 1'b1;
          if (cell_valid) begin
            beat_d = beat_q + CW'(1);
            if (!cell_old && cell_new) partial_d = partial_q + CW'(1);
            if (beat_q == LAST_BEAT) state_d = COMMIT;
          end
        end
        COMMIT: begin
          if (gen_start || cell_valid) perr_d = 1'b1;
          state_d  = IDLE;
          births_d = births_next;
          gen_d    = gen_next;
          commit_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign births       = births_q;
  assign generation   = gen_q;
  assign busy         = busy_q;
  assign commit       = commit_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_life_stats_counter.sv
// Directed self-checking bench for life_stats_counter (CELLS=4, MAX_COUNT=10).
// Expectations follow LIFE_STATS_PER_GEN_EN when it is defined.
module tb_life_stats_counter;

  localparam int unsigned CELLS = 4;
  localparam int unsigned MAXC  = 10;
`ifdef LIFE_STATS_PER_GEN_EN
  localparam bit PER_GEN = 1'b1;
`else
  localparam bit PER_GEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        gen_start = 1'b0;
  logic        cell_valid = 1'b0;
  logic        cell_old = 1'b0;
  logic        cell_new = 1'b0;
  logic [15:0] births;
  logic [15:0] generation;
  logic        busy;
  logic        commit;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;
  int exp_b  = 0;

  always #5 clk = ~clk;

  life_stats_counter #(.CELLS(CELLS), .MAX_COUNT(MAXC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .gen_start    (gen_start),
    .cell_valid   (cell_valid),
    .cell_old     (cell_old),
    .cell_new     (cell_new),
    .births       (births),
    .generation   (generation),
    .busy         (busy),
    .commit       (commit),
    .protocol_err (protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int b, input int g, input logic bz,
                      input logic cm, input logic pe);
    chk({tag, ".births"}, 32'(births), 32'(b));
    chk({tag, ".generation"}, 32'(generation), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".commit"}, 32'(commit), 32'(cm));
    chk({tag, ".protocol_err"}, 32'(protocol_err), 32'(pe));
  endtask

  task automatic beat(input logic o, input logic n);
    cell_valid = 1'b1;
    cell_old   = o;
    cell_new   = n;
    tick();
    cell_valid = 1'b0;
    cell_old   = 1'b0;
    cell_new   = 1'b0;
  endtask

  // Full sweep; returns just after the commit edge (commit expected high).
  task automatic sweep(input logic [3:0] olds, input logic [3:0] news);
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    for (int i = 0; i < 4; i++) beat(olds[i], news[i]);
    tick();
  endtask

  initial begin
    // Reset held, then released with no stimulus.
    repeat (3) @(posedge clk);
    #1;
    outs("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      outs("idle", 0, 0, 1'b0, 1'b0, 1'b0);
    end

    // Single sweep with edge-accurate timing: beats 0/1, 1/1, 0/1, 1/0.
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    outs("commit_state", 0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    outs("single", 2, 1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("commit_fall", 32'(commit), 32'd0);
    chk("births_hold", 32'(births), 32'd2);

    // Accumulation: second sweep 0 births, third sweep 3 births.
    sweep(4'b1111, 4'b1111);
    outs("acc2", PER_GEN ? 0 : 2, 2, 1'b0, 1'b1, 1'b0);
    tick();
    sweep(4'b1000, 4'b0111);
    exp_b = PER_GEN ? 3 : 5;
    outs("acc3", exp_b, 3, 1'b0, 1'b1, 1'b0);
    tick();

    // cell_valid in IDLE: flagged, nothing counted.
    cell_valid = 1'b1;
    cell_old   = 1'b0;
    cell_new   = 1'b1;
    tick();
    cell_valid = 1'b0;
    cell_new   = 1'b0;
    outs("valid_idle", exp_b, 3, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    outs("valid_idle_hold", exp_b, 3, 1'b0, 1'b0, 1'b1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    outs("clear_idle", 0, 0, 1'b0, 1'b0, 1'b0);

    // gen_start mid-SCAN is ignored; sweep still completes correctly.
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    chk("gs_scan_err", 32'(protocol_err), 32'd1);
    chk("gs_scan_busy", 32'(busy), 32'd1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b1);
    tick();
    outs("gs_scan", 2, 1, 1'b0, 1'b1, 1'b1);
    tick();

    // Clear after 2 of 4 beats discards the sweep.
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    outs("clear_mid", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    sweep(4'b1110, 4'b1111);
    outs("after_clear", 1, 1, 1'b0, 1'b1, 1'b0);
    tick();

    // Saturation: twelve back-to-back all-birth sweeps, each new
    // gen_start issued in the cycle where commit is high.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int s = 1; s <= 12; s++) begin
      sweep(4'b0000, 4'b1111);
      exp_b = PER_GEN ? 4 : ((4 * s > 10) ? 10 : 4 * s);
      chk($sformatf("sat%0d.commit", s), 32'(commit), 32'd1);
      chk($sformatf("sat%0d.births", s), 32'(births), 32'(exp_b));
      chk($sformatf("sat%0d.generation", s), 32'(generation), 32'((s > 10) ? 10 : s));
      chk($sformatf("sat%0d.protocol_err", s), 32'(protocol_err), 32'd0);
    end
    tick();
    outs("sat_final", PER_GEN ? 4 : 10, 10, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-sweep.
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    beat(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    outs("reset_mid", 0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    outs("reset_mid_idle", 0, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
